// File: rtl/cam_vip_pkg.sv
// Shared types for the camera receive path: FSM states, error codes, RGB565 pixel.
package cam_vip_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_VSYNC     = 2'd1,
        ST_WAIT_LINE = 2'd2,
        ST_LINE      = 2'd3
    } cam_state_e;

    typedef enum logic [2:0] {
        ERR_NONE          = 3'd0,
        ERR_ODD_BYTES     = 3'd1,
        ERR_LINE_LEN      = 3'd2,
        ERR_VSYNC_POS     = 3'd3,
        ERR_HREF_IN_VSYNC = 3'd4,
        ERR_LINE_LONG     = 3'd5
    } cam_err_e;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // Position counters stick at all-ones instead of wrapping back to a valid index.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cam_rx_pixel_pack.sv
// Byte-phase tracker: holds the high byte and presents {byte0, current byte} as a pixel.
module cam_rx_pixel_pack
    import cam_vip_pkg::*;
(
    input  logic       cam_clk_o,
    input  logic       s_rstn,
    input  logic       clr_i,
    input  logic       sample_i,
    input  logic [7:0] data_i,
    output logic       phase_o,
    output rgb565_t    pix_o
);

    logic       phase_q, phase_d;
    logic [7:0] byte0_q, byte0_d;

    always_comb begin
        phase_d = phase_q;
        byte0_d = byte0_q;
        if (clr_i) begin
            phase_d = 1'b0;
        end else if (sample_i) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                byte0_d = data_i;
            end
        end
    end

    always_ff @(posedge cam_clk_o or negedge s_rstn) begin
        if (!s_rstn) begin
            phase_q <= 1'b0;
            byte0_q <= 8'h00;
        end else begin
            phase_q <= phase_d;
            byte0_q <= byte0_d;
        end
    end

    assign phase_o = phase_q;
    assign pix_o   = rgb565_t'({byte0_q, data_i});

endmodule

// File: rtl/cam_rx_monitor.sv
// Camera DVP receive monitor: frame/line tracking, pixel output, first-error capture.
//   state        | meaning
//   ST_IDLE      | waiting for vsync, href ignored
//   ST_VSYNC     | inside vsync pulse, waiting for its fall
//   ST_WAIT_LINE | between lines, waiting for href rise
//   ST_LINE      | href high, bytes being paired into pixels
module cam_rx_monitor
    import cam_vip_pkg::*;
#(
    parameter int HRES = 640,
    parameter int VRES = 480
) (
    input  logic        cam_clk_o,
    input  logic        s_rstn,
    input  logic        en_i,
    input  logic        cam_vsync_i,
    input  logic        cam_href_i,
    input  logic [7:0]  cam_data_i,
    output logic        pix_valid_o,
    output logic [15:0] pix_data_o,
    output logic [15:0] pix_col_o,
    output logic [15:0] pix_line_o,
    output logic        sof_o,
    output logic        eof_o,
    output logic [15:0] frame_cnt_o,
    output logic        err_o,
    output logic [2:0]  err_code_o
);

    localparam logic [15:0] HRES_W = 16'(HRES);
    localparam logic [15:0] VRES_W = 16'(VRES);

    cam_state_e  st_q, st_d;
    logic [15:0] col_q, col_d, line_q, line_d, frame_q, frame_d;
    logic        err_q, err_d, ferr_q, ferr_d;
    cam_err_e    code_q, code_d, err_now;
    logic        pv_q, pv_d, sof_q, sof_d, eof_q, eof_d;
    rgb565_t     pd_q, pd_d;
    logic [15:0] pc_q, pc_d, pl_q, pl_d;
    logic        pk_clr, pk_sample, pk_phase;
    rgb565_t     pk_pix;

    cam_rx_pixel_pack u_pack (
        .cam_clk_o (cam_clk_o),
        .s_rstn    (s_rstn),
        .clr_i     (pk_clr),
        .sample_i  (pk_sample),
        .data_i    (cam_data_i),
        .phase_o   (pk_phase),
        .pix_o     (pk_pix)
    );

    always_comb begin
        st_d      = st_q;
        col_d     = col_q;
        line_d    = line_q;
        frame_d   = frame_q;
        err_d     = err_q;
        code_d    = code_q;
        ferr_d    = ferr_q;
        pv_d      = 1'b0;
        pd_d      = pd_q;
        pc_d      = pc_q;
        pl_d      = pl_q;
        sof_d     = 1'b0;
        eof_d     = 1'b0;
        pk_clr    = 1'b0;
        pk_sample = 1'b0;
        err_now   = ERR_NONE;

        if (!en_i) begin
            st_d   = ST_IDLE;
            col_d  = '0;
            line_d = '0;
            pk_clr = 1'b1;
        end else begin
            unique case (st_q)
                ST_IDLE: begin
                    if (cam_vsync_i) st_d = ST_VSYNC;
                end
                ST_VSYNC: begin
                    if (!cam_vsync_i) begin
                        st_d   = ST_WAIT_LINE;
                        line_d = '0;
                        col_d  = '0;
                        sof_d  = 1'b1;
                        pk_clr = 1'b1;
                    end else if (cam_href_i) begin
                        err_now = ERR_HREF_IN_VSYNC;
                    end
                end
                ST_WAIT_LINE: begin
                    if (cam_vsync_i) begin
                        // A repeated vsync before any line is harmless; after a line it aborts the frame.
                        st_d = ST_VSYNC;
                        if (line_q != '0) err_now = ERR_VSYNC_POS;
                    end else if (cam_href_i) begin
                        st_d      = ST_LINE;
                        col_d     = '0;
                        pk_sample = 1'b1;
                    end
                end
                ST_LINE: begin
                    if (cam_vsync_i) begin
                        st_d    = ST_VSYNC;
                        err_now = ERR_VSYNC_POS;
                        pk_clr  = 1'b1;
                    end else if (cam_href_i) begin
                        pk_sample = 1'b1;
                        if (pk_phase) begin
                            if (col_q < HRES_W) begin
                                pv_d = 1'b1;
                                pd_d = pk_pix;
                                pc_d = col_q;
                                pl_d = line_q;
                            end else begin
                                err_now = ERR_LINE_LONG;
                            end
                            col_d = sat_inc16(col_q);
                        end
                    end else begin
                        pk_clr = 1'b1;
                        if (pk_phase)             err_now = ERR_ODD_BYTES;
                        else if (col_q != HRES_W) err_now = ERR_LINE_LEN;
                        line_d = sat_inc16(line_q);
                        if (line_d == VRES_W) begin
                            st_d  = ST_IDLE;
                            eof_d = 1'b1;
                            if (!ferr_q && (err_now == ERR_NONE)) frame_d = frame_q + 16'd1;
                        end else begin
                            st_d = ST_WAIT_LINE;
                        end
                    end
                end
                default: st_d = ST_IDLE;
            endcase
        end

        if ((err_now != ERR_NONE) && !err_q) begin
            err_d  = 1'b1;
            code_d = err_now;
        end

        // Entering VSYNC starts a new frame, so an abort's own error stays with the old one.
        if ((st_d == ST_VSYNC) && (st_q != ST_VSYNC)) ferr_d = 1'b0;
        else if (err_now != ERR_NONE)                 ferr_d = 1'b1;
    end

    always_ff @(posedge cam_clk_o or negedge s_rstn) begin
        if (!s_rstn) begin
            st_q    <= ST_IDLE;
            col_q   <= '0;
            line_q  <= '0;
            frame_q <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            ferr_q  <= 1'b0;
            pv_q    <= 1'b0;
            pd_q    <= '0;
            pc_q    <= '0;
            pl_q    <= '0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            col_q   <= col_d;
            line_q  <= line_d;
            frame_q <= frame_d;
            err_q   <= err_d;
            code_q  <= code_d;
            ferr_q  <= ferr_d;
            pv_q    <= pv_d;
            pd_q    <= pd_d;
            pc_q    <= pc_d;
            pl_q    <= pl_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
        end
    end

    assign pix_valid_o = pv_q;
    assign pix_data_o  = pd_q;
    assign pix_col_o   = pc_q;
    assign pix_line_o  = pl_q;
    assign sof_o       = sof_q;
    assign eof_o       = eof_q;
    assign frame_cnt_o = frame_q;
    assign err_o       = err_q;
    assign err_code_o  = code_q;

endmodule

// File: tb/tb_cam_rx_monitor.sv
// Bench for cam_rx_monitor: frame-shape table, directed corner sequences, random frames vs model.
module tb_cam_rx_monitor;

    localparam int HRES = 4;
    localparam int VRES = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic        vs = 1'b0;
    logic        hr = 1'b0;
    logic [7:0]  d = 8'h00;
    logic        pix_valid_o, sof_o, eof_o, err_o;
    logic [15:0] pix_data_o, pix_col_o, pix_line_o, frame_cnt_o;
    logic [2:0]  err_code_o;

    always #5 clk = ~clk;

    cam_rx_monitor #(.HRES(HRES), .VRES(VRES)) dut (
        .cam_clk_o   (clk),
        .s_rstn      (rstn),
        .en_i        (en),
        .cam_vsync_i (vs),
        .cam_href_i  (hr),
        .cam_data_i  (d),
        .pix_valid_o (pix_valid_o),
        .pix_data_o  (pix_data_o),
        .pix_col_o   (pix_col_o),
        .pix_line_o  (pix_line_o),
        .sof_o       (sof_o),
        .eof_o       (eof_o),
        .frame_cnt_o (frame_cnt_o),
        .err_o       (err_o),
        .err_code_o  (err_code_o)
    );

    int n_chk = 0;
    int n_err = 0;
    int pix_cnt = 0;
    int sof_cnt = 0;
    int eof_cnt = 0;
    int mdl_code = 0;
    int mdl_frames = 0;

    typedef struct { logic [15:0] data; int col; int line; } pix_t;
    pix_t exp_q[$];
    pix_t e;

    typedef struct { int len0; int len1; int code; int frames; int pix; } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sof_o) sof_cnt++;
        if (eof_o) eof_cnt++;
        if (pix_valid_o) begin
            pix_cnt++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_pixel: actual=%0h required=none", pix_data_o);
            end else begin
                e = exp_q.pop_front();
                chk("pix_data", pix_data_o, e.data);
                chk("pix_col", pix_col_o, e.col);
                chk("pix_line", pix_line_o, e.line);
            end
        end
    end

    task automatic cyc(input logic v, input logic h, input logic [7:0] b);
        vs = v; hr = h; d = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic vsync_pulse();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h00);
        idle(2);
    endtask

    // Expected pixels: every complete byte pair, but only the first HRES of a line.
    task automatic drive_line(input int n, input int ln, input bit rnd);
        logic [7:0] bs[$];
        for (int i = 0; i < n; i++)
            bs.push_back(rnd ? 8'($urandom) : ((i % 2 == 0) ? 8'hF8 : 8'h1F));
        for (int k = 0; k < n / 2; k++)
            if (k < HRES) exp_q.push_back('{{bs[2*k], bs[2*k+1]}, k, ln});
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, bs[i]);
        idle(rnd ? int'($urandom_range(1, 3)) : 2);
    endtask

    function automatic int line_code(input int n);
        if (n >= 2 * HRES + 2) return 5;
        if (n % 2 != 0)        return 1;
        if (n / 2 != HRES)     return 2;
        return 0;
    endfunction

    task automatic frame(input int len0, input int len1, input bit rnd);
        int fc;
        vsync_pulse();
        drive_line(len0, 0, rnd);
        drive_line(len1, 1, rnd);
        idle(3);
        fc = line_code(len0);
        if (fc == 0) fc = line_code(len1);
        if (mdl_code == 0) mdl_code = fc;
        if (fc == 0) mdl_frames = (mdl_frames + 1) % 65536;
    endtask

    task automatic do_reset();
        vs = 1'b0; hr = 1'b0; d = 8'h00;
        #2 rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        en = 1'b1;
        exp_q.delete();
        pix_cnt = 0; sof_cnt = 0; eof_cnt = 0;
        mdl_code = 0; mdl_frames = 0;
        idle(2);
    endtask

    initial begin
        tbl[0] = '{8, 8, 0, 1, 8};
        tbl[1] = '{7, 8, 1, 0, 7};
        tbl[2] = '{6, 10, 2, 0, 7};
        tbl[3] = '{10, 8, 5, 0, 8};
        tbl[4] = '{9, 8, 1, 0, 8};
        tbl[5] = '{8, 2, 2, 0, 5};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_pix_valid", pix_valid_o, 0);
        chk("rst_pix_data", pix_data_o, 0);
        chk("rst_sof", sof_o, 0);
        chk("rst_eof", eof_o, 0);
        chk("rst_frame_cnt", frame_cnt_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_err_code", err_code_o, 0);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            frame(tbl[i].len0, tbl[i].len1, 1'b0);
            chk($sformatf("tbl%0d_code", i), err_code_o, tbl[i].code);
            chk($sformatf("tbl%0d_err", i), err_o, (tbl[i].code != 0) ? 1 : 0);
            chk($sformatf("tbl%0d_frames", i), frame_cnt_o, tbl[i].frames);
            chk($sformatf("tbl%0d_pix", i), pix_cnt, tbl[i].pix);
            chk($sformatf("tbl%0d_sof", i), sof_cnt, 1);
            chk($sformatf("tbl%0d_eof", i), eof_cnt, 1);
        end

        // Mid-frame vsync after line 0, then a legal frame.
        do_reset();
        vsync_pulse();
        drive_line(8, 0, 1'b0);
        vsync_pulse();
        chk("abort_code", err_code_o, 3);
        chk("abort_no_eof", eof_cnt, 0);
        drive_line(8, 0, 1'b0);
        drive_line(8, 1, 1'b0);
        idle(3);
        chk("abort_sof", sof_cnt, 2);
        chk("abort_eof", eof_cnt, 1);
        chk("abort_frames", frame_cnt_o, 1);
        chk("abort_code_kept", err_code_o, 3);

        // href during vsync, then async reset.
        do_reset();
        frame(8, 8, 1'b0);
        chk("hv_frames_pre", frame_cnt_o, 1);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 8'h55);
        cyc(1'b1, 1'b0, 8'h00);
        idle(2);
        drive_line(8, 0, 1'b0);
        drive_line(8, 1, 1'b0);
        idle(3);
        chk("hv_code", err_code_o, 4);
        chk("hv_err", err_o, 1);
        chk("hv_frames", frame_cnt_o, 1);
        chk("hv_eof", eof_cnt, 2);
        #2 rstn = 1'b0;
        #1;
        chk("hv_rst_err", err_o, 0);
        chk("hv_rst_code", err_code_o, 0);
        chk("hv_rst_frames", frame_cnt_o, 0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Disable mid-line, re-enable, resynchronise.
        do_reset();
        frame(8, 8, 1'b0);
        pix_cnt = 0;
        vsync_pulse();
        exp_q.push_back('{16'hF81F, 0, 0});
        exp_q.push_back('{16'hF81F, 1, 0});
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, (i % 2 == 0) ? 8'hF8 : 8'h1F);
        en = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'hAA);
        chk("dis_pix", pix_cnt, 2);
        chk("dis_frames", frame_cnt_o, 1);
        en = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'h33);
        idle(2);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 8'h44);
        idle(3);
        chk("dis_pix_idle", pix_cnt, 2);
        chk("dis_err", err_o, 0);
        frame(8, 8, 1'b0);
        chk("dis_frames_after", frame_cnt_o, 2);
        chk("dis_pix_after", pix_cnt, 10);
        chk("dis_eof", eof_cnt, 2);

        // Random frames against the model.
        do_reset();
        for (int f = 0; f < 12; f++) begin
            int l0, l1;
            l0 = ($urandom_range(0, 9) < 6) ? 2 * HRES : int'($urandom_range(1, 12));
            l1 = ($urandom_range(0, 9) < 6) ? 2 * HRES : int'($urandom_range(1, 12));
            frame(l0, l1, 1'b1);
            idle(int'($urandom_range(0, 4)));
            chk($sformatf("rnd%0d_frames", f), frame_cnt_o, mdl_frames);
            chk($sformatf("rnd%0d_code", f), err_code_o, mdl_code);
            chk($sformatf("rnd%0d_eof", f), eof_cnt, f + 1);
        end
        chk("rnd_sof", sof_cnt, 12);
        chk("rnd_pix_left", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
